// File: rtl/collision_detector_pkg.sv
// Shared game definitions: packed position format, dead marker, hitbox sizes and slot counts.
// Used by the bullet generator and the collision detector.
package collision_detector_pkg;

  localparam int POS_W = 19;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  // Overlap arithmetic width: wide enough that coordinate + hitbox size never wraps.
  localparam int CMP_W = 11;

  localparam logic [POS_W-1:0] DEAD_POSITION = 19'h7FFFF;

  localparam int BULLET_W = 6;
  localparam int BULLET_H = 20;
  localparam int OBJ_W    = 36;
  localparam int OBJ_H    = 36;

  localparam int ENEMY_SLOTS   = 15;
  localparam int PBULLET_SLOTS = 16;
  localparam int EBULLET_SLOTS = 30;

  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 999;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_PB,
    SCAN_EB,
    DONE
  } scanState_t;

endpackage

// File: rtl/collision_detector_overlap.sv
// Axis-aligned hitbox overlap between a bullet box (A) and an object box (B).
// Purely combinational; no state, no flow control.
// A dead-marked position on either side never reports a hit.
module hitbox_overlap
  import collision_detector_pkg::*;
#(
  parameter int A_W = BULLET_W,
  parameter int A_H = BULLET_H,
  parameter int B_W = OBJ_W,
  parameter int B_H = OBJ_H
) (
  input  logic             i_AValid,
  input  logic [POS_W-1:0] i_APos,
  input  logic             i_BValid,
  input  logic [POS_W-1:0] i_BPos,
  output logic             o_Hit
);

  localparam logic [CMP_W-1:0] AW = CMP_W'(A_W);
  localparam logic [CMP_W-1:0] AH = CMP_W'(A_H);
  localparam logic [CMP_W-1:0] BW = CMP_W'(B_W);
  localparam logic [CMP_W-1:0] BH = CMP_W'(B_H);

  pos_t a;
  pos_t b;
  logic [CMP_W-1:0] ax, ay, bx, by;
  logic xOverlap, yOverlap, bothLive;

  assign a  = pos_t'(i_APos);
  assign b  = pos_t'(i_BPos);
  assign ax = CMP_W'(a.x);
  assign ay = CMP_W'(a.y);
  assign bx = CMP_W'(b.x);
  assign by = CMP_W'(b.y);

  assign xOverlap = (ax < bx + BW) && (bx < ax + AW);
  assign yOverlap = (ay < by + BH) && (by < ay + AH);
  assign bothLive = i_AValid && i_BValid &&
                    (i_APos != DEAD_POSITION) && (i_BPos != DEAD_POSITION);

  assign o_Hit = bothLive && xOverlap && yOverlap;

endmodule

// File: rtl/collision_detector.sv
// Per-frame collision scan: player bullets vs enemies, then enemy bullets vs player.
// Latency i_fTick to o_fDone is MAX_PLAYER_BULLET+MAX_ENEMY_BULLET+1 cycles.
// No backpressure; i_fTick during a scan is dropped and bullet reads expect same-cycle data.
module collision_detector
  import collision_detector_pkg::*;
#(
  parameter int MAX_ENEMY         = ENEMY_SLOTS,
  parameter int MAX_PLAYER_BULLET = PBULLET_SLOTS,
  parameter int MAX_ENEMY_BULLET  = EBULLET_SLOTS,
  parameter int BULLET_WIDTH      = BULLET_W,
  parameter int BULLET_HEIGHT     = BULLET_H,
  parameter int OBJ_WIDTH         = OBJ_W,
  parameter int OBJ_HEIGHT        = OBJ_H
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_fTick,
  input  logic [MAX_ENEMY-1:0]         i_EnemyState,
  input  logic [POS_W*MAX_ENEMY-1:0]   i_EnemyPosFlat,
  input  logic                         i_PlayerState,
  input  logic [POS_W-1:0]             i_PlayerPos,
  output logic [3:0]                   o_PBulletIdx,
  input  logic                         i_PBulletAlive,
  input  logic [POS_W-1:0]             i_PBulletPos,
  output logic [4:0]                   o_EBulletIdx,
  input  logic                         i_EBulletAlive,
  input  logic [POS_W-1:0]             i_EBulletPos,
  output logic [MAX_ENEMY-1:0]         o_EnemyKill,
  output logic [MAX_PLAYER_BULLET-1:0] o_PBulletKill,
  output logic [MAX_ENEMY_BULLET-1:0]  o_EBulletKill,
  output logic                         o_fPlayerHit,
  output logic                         o_fDone,
  output logic                         o_Busy,
  output logic [SCORE_W-1:0]           o_Score
);

  localparam logic [4:0] LAST_PB = 5'(MAX_PLAYER_BULLET - 1);
  localparam logic [4:0] LAST_EB = 5'(MAX_ENEMY_BULLET - 1);
  localparam logic [SCORE_W:0] SCORE_CAP = (SCORE_W+1)'(SCORE_MAX);

  scanState_t state, stateNxt;
  logic [4:0] idx, idxNxt;

  logic [MAX_ENEMY-1:0]         enemyKillW, enemyKillNxt;
  logic [MAX_PLAYER_BULLET-1:0] pBulletKillW, pBulletKillNxt;
  logic [MAX_ENEMY_BULLET-1:0]  eBulletKillW, eBulletKillNxt;
  logic                         playerHitW, playerHitNxt;

  logic [MAX_ENEMY-1:0] enemyOverlap;
  logic [MAX_ENEMY-1:0] enemyHitLow;
  logic                 eBulletHit;
  logic                 scanEnd;

  logic [SCORE_W:0] killCount;
  logic [SCORE_W:0] scoreSum;
  logic [SCORE_W-1:0] scoreNxt;

  // Enemies already killed this scan are masked off so later bullets pass through them.
  for (genvar k = 0; k < MAX_ENEMY; k++) begin : gEnemyHit
    hitbox_overlap #(
      .A_W(BULLET_WIDTH), .A_H(BULLET_HEIGHT), .B_W(OBJ_WIDTH), .B_H(OBJ_HEIGHT)
    ) uOverlap (
      .i_AValid(i_PBulletAlive),
      .i_APos  (i_PBulletPos),
      .i_BValid(i_EnemyState[k] & ~enemyKillW[k]),
      .i_BPos  (i_EnemyPosFlat[POS_W*k +: POS_W]),
      .o_Hit   (enemyOverlap[k])
    );
  end

  hitbox_overlap #(
    .A_W(BULLET_WIDTH), .A_H(BULLET_HEIGHT), .B_W(OBJ_WIDTH), .B_H(OBJ_HEIGHT)
  ) uPlayerHit (
    .i_AValid(i_EBulletAlive),
    .i_APos  (i_EBulletPos),
    .i_BValid(i_PlayerState),
    .i_BPos  (i_PlayerPos),
    .o_Hit   (eBulletHit)
  );

  // Isolate the lowest set bit: a bullet is consumed by one enemy only.
  assign enemyHitLow = enemyOverlap & (-enemyOverlap);

  always_comb begin
    stateNxt       = state;
    idxNxt         = idx;
    enemyKillNxt   = enemyKillW;
    pBulletKillNxt = pBulletKillW;
    eBulletKillNxt = eBulletKillW;
    playerHitNxt   = playerHitW;
    unique case (state)
      IDLE: begin
        if (i_fTick) begin
          stateNxt       = SCAN_PB;
          idxNxt         = '0;
          enemyKillNxt   = '0;
          pBulletKillNxt = '0;
          eBulletKillNxt = '0;
          playerHitNxt   = 1'b0;
        end
      end
      SCAN_PB: begin
        if (|enemyOverlap) begin
          enemyKillNxt              = enemyKillW | enemyHitLow;
          pBulletKillNxt[idx[3:0]] = 1'b1;
        end
        if (idx == LAST_PB) begin
          stateNxt = SCAN_EB;
          idxNxt   = '0;
        end else begin
          idxNxt = idx + 5'd1;
        end
      end
      SCAN_EB: begin
        if (eBulletHit) begin
          eBulletKillNxt[idx] = 1'b1;
          playerHitNxt        = 1'b1;
        end
        if (idx == LAST_EB) begin
          stateNxt = DONE;
          idxNxt   = '0;
        end else begin
          idxNxt = idx + 5'd1;
        end
      end
      DONE: begin
        stateNxt = IDLE;
        idxNxt   = '0;
      end
      default: begin
        stateNxt = IDLE;
        idxNxt   = '0;
      end
    endcase
  end

  // Results are published on the edge entering DONE so they are valid alongside o_fDone.
  assign scanEnd = (state == SCAN_EB) && (idx == LAST_EB);

  always_comb begin
    killCount = '0;
    for (int i = 0; i < MAX_ENEMY; i++) begin
      killCount = killCount + (SCORE_W+1)'(enemyKillNxt[i]);
    end
  end

  assign scoreSum = (SCORE_W+1)'(o_Score) + killCount;
  assign scoreNxt = (scoreSum > SCORE_CAP) ? SCORE_CAP[SCORE_W-1:0] : scoreSum[SCORE_W-1:0];

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state         <= IDLE;
      idx           <= '0;
      enemyKillW    <= '0;
      pBulletKillW  <= '0;
      eBulletKillW  <= '0;
      playerHitW    <= 1'b0;
      o_EnemyKill   <= '0;
      o_PBulletKill <= '0;
      o_EBulletKill <= '0;
      o_fPlayerHit  <= 1'b0;
      o_Score       <= '0;
    end else begin
      state        <= stateNxt;
      idx          <= idxNxt;
      enemyKillW   <= enemyKillNxt;
      pBulletKillW <= pBulletKillNxt;
      eBulletKillW <= eBulletKillNxt;
      playerHitW   <= playerHitNxt;
      if (scanEnd) begin
        o_EnemyKill   <= enemyKillNxt;
        o_PBulletKill <= pBulletKillNxt;
        o_EBulletKill <= eBulletKillNxt;
        o_fPlayerHit  <= playerHitNxt;
        o_Score       <= scoreNxt;
      end
    end
  end

  assign o_Busy       = (state != IDLE);
  assign o_fDone      = (state == DONE);
  assign o_PBulletIdx = (state == SCAN_PB) ? idx[3:0] : 4'd0;
  assign o_EBulletIdx = (state == SCAN_EB) ? idx : 5'd0;

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: hand-computed kill masks, latency, score and reset behaviour.
module tb_collision_detector;
  import collision_detector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN;
  logic         fTick;
  logic [14:0]  enemyState;
  logic [284:0] enemyPosFlat;
  logic         playerState;
  logic [18:0]  playerPos;
  logic [3:0]   pBulletIdx;
  logic         pBulletAlive;
  logic [18:0]  pBulletPos;
  logic [4:0]   eBulletIdx;
  logic         eBulletAlive;
  logic [18:0]  eBulletPos;
  logic [14:0]  enemyKill;
  logic [15:0]  pBulletKill;
  logic [29:0]  eBulletKill;
  logic         playerHit;
  logic         fDone;
  logic         busy;
  logic [9:0]   score;

  logic        pbAlive [16];
  logic [18:0] pbPos   [16];
  logic        ebAlive [32];
  logic [18:0] ebPos   [32];

  assign pBulletAlive = pbAlive[pBulletIdx];
  assign pBulletPos   = pbPos[pBulletIdx];
  assign eBulletAlive = ebAlive[eBulletIdx];
  assign eBulletPos   = ebPos[eBulletIdx];

  collision_detector dut (
    .i_Clk(clk), .i_Rst(rstN), .i_fTick(fTick),
    .i_EnemyState(enemyState), .i_EnemyPosFlat(enemyPosFlat),
    .i_PlayerState(playerState), .i_PlayerPos(playerPos),
    .o_PBulletIdx(pBulletIdx), .i_PBulletAlive(pBulletAlive), .i_PBulletPos(pBulletPos),
    .o_EBulletIdx(eBulletIdx), .i_EBulletAlive(eBulletAlive), .i_EBulletPos(eBulletPos),
    .o_EnemyKill(enemyKill), .o_PBulletKill(pBulletKill), .o_EBulletKill(eBulletKill),
    .o_fPlayerHit(playerHit), .o_fDone(fDone), .o_Busy(busy), .o_Score(score)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] mkPos(input int x, input int y);
    return {10'(x), 9'(y)};
  endfunction

  task automatic clearField();
    for (int i = 0; i < 32; i++) begin
      ebAlive[i] = 1'b0;
      ebPos[i]   = DEAD_POSITION;
    end
    for (int i = 0; i < 16; i++) begin
      pbAlive[i] = 1'b0;
      pbPos[i]   = DEAD_POSITION;
    end
    enemyState   = '0;
    enemyPosFlat = '1;
    playerState  = 1'b0;
    playerPos    = DEAD_POSITION;
  endtask

  task automatic setEnemy(input int k, input logic alive, input logic [18:0] pos);
    enemyState[k]           = alive;
    enemyPosFlat[19*k +: 19] = pos;
  endtask

  // Pulses i_fTick and returns at the negedge where o_fDone is seen (cycle count from the tick).
  task automatic runScan(output int doneAt, output logic busyAt1);
    doneAt  = -1;
    busyAt1 = 1'b0;
    @(negedge clk);
    fTick = 1'b1;
    @(negedge clk);
    fTick = 1'b0;
    busyAt1 = busy;
    for (int c = 1; c <= 100; c++) begin
      if (fDone) begin
        doneAt = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  int   doneAt;
  logic busy1;
  int   doneCount;
  int   firstDone;
  logic [3:0] pIdxAt5;
  logic [4:0] eIdxAt20;

  initial begin
    rstN  = 1'b0;
    fTick = 1'b0;
    clearField();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", fDone, 0);
    check("rst_score", score, 0);
    check("rst_enemy_kill", enemyKill, 0);
    check("rst_pb_kill", pBulletKill, 0);
    check("rst_eb_kill", eBulletKill, 0);
    check("rst_player_hit", playerHit, 0);
    check("rst_pidx", pBulletIdx, 0);
    check("rst_eidx", eBulletIdx, 0);
    rstN = 1'b1;

    // Single hit: bullet 3 on enemy 7
    clearField();
    setEnemy(7, 1'b1, mkPos(290, 90));
    pbAlive[3] = 1'b1;
    pbPos[3]   = mkPos(300, 100);
    runScan(doneAt, busy1);
    check("basic_latency", doneAt, 47);
    check("basic_busy", busy1, 1);
    check("basic_enemy_kill", enemyKill, 15'h0080);
    check("basic_pb_kill", pBulletKill, 16'h0008);
    check("basic_score", score, 1);
    check("basic_done_idx", pBulletIdx, 0);

    // Two bullets on one enemy; one bullet over two enemies kills the lower index
    clearField();
    setEnemy(2, 1'b1, mkPos(100, 50));
    setEnemy(5, 1'b1, mkPos(500, 200));
    setEnemy(9, 1'b1, mkPos(500, 200));
    pbAlive[0] = 1'b1; pbPos[0] = mkPos(110, 60);
    pbAlive[1] = 1'b1; pbPos[1] = mkPos(120, 60);
    pbAlive[4] = 1'b1; pbPos[4] = mkPos(505, 210);
    runScan(doneAt, busy1);
    check("multi_latency", doneAt, 47);
    check("multi_enemy_kill", enemyKill, 15'h0024);
    check("multi_pb_kill", pBulletKill, 16'h0011);
    check("multi_score", score, 3);

    // Enemy bullets on the player
    clearField();
    playerState = 1'b1;
    playerPos   = mkPos(302, 372);
    ebAlive[5]  = 1'b1; ebPos[5]  = mkPos(310, 380);
    ebAlive[20] = 1'b1; ebPos[20] = mkPos(330, 400);
    ebAlive[7]  = 1'b1; ebPos[7]  = DEAD_POSITION;
    ebAlive[8]  = 1'b1; ebPos[8]  = mkPos(290, 360);
    ebAlive[9]  = 1'b1; ebPos[9]  = mkPos(338, 372);
    runScan(doneAt, busy1);
    check("eb_latency", doneAt, 47);
    check("eb_kill", eBulletKill, 30'h0010_0020);
    check("eb_player_hit", playerHit, 1);
    check("eb_enemy_kill", enemyKill, 0);
    check("eb_score", score, 3);

    playerState = 1'b0;
    runScan(doneAt, busy1);
    check("eb_dead_player_kill", eBulletKill, 0);
    check("eb_dead_player_hit", playerHit, 0);

    // Dead-marker and edge-touch boundaries
    clearField();
    setEnemy(0, 1'b1, DEAD_POSITION);
    setEnemy(1, 1'b1, mkPos(200, 100));
    setEnemy(14, 1'b1, mkPos(1000, 480));
    pbAlive[0] = 1'b1; pbPos[0] = DEAD_POSITION;
    pbAlive[1] = 1'b1; pbPos[1] = mkPos(236, 100);
    pbAlive[2] = 1'b1; pbPos[2] = mkPos(194, 100);
    pbAlive[5] = 1'b1; pbPos[5] = mkPos(200, 136);
    pbAlive[6] = 1'b1; pbPos[6] = mkPos(200, 80);
    pbAlive[3] = 1'b1; pbPos[3] = mkPos(235, 135);
    pbAlive[7] = 1'b1; pbPos[7] = mkPos(1020, 500);
    runScan(doneAt, busy1);
    check("edge_enemy_kill", enemyKill, 15'h4002);
    check("edge_pb_kill", pBulletKill, 16'h0088);
    check("edge_score", score, 5);

    // Re-tick mid-scan is ignored; index outputs walk the slots
    clearField();
    doneCount = 0;
    firstDone = -1;
    pIdxAt5   = 4'hF;
    eIdxAt20  = 5'h1F;
    @(negedge clk);
    fTick = 1'b1;
    @(negedge clk);
    fTick = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      if (fDone) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
      end
      if (c == 5)  pIdxAt5  = pBulletIdx;
      if (c == 20) eIdxAt20 = eBulletIdx;
      fTick = (c == 10);
      @(negedge clk);
    end
    fTick = 1'b0;
    check("retick_done_count", doneCount, 1);
    check("retick_done_cycle", firstDone, 47);
    check("scan_pidx_c5", pIdxAt5, 4);
    check("scan_eidx_c20", eIdxAt20, 3);
    check("retick_score", score, 5);

    // Reset mid-scan aborts with no completion pulse
    clearField();
    setEnemy(7, 1'b1, mkPos(290, 90));
    pbAlive[3] = 1'b1;
    pbPos[3]   = mkPos(300, 100);
    doneCount = 0;
    @(negedge clk);
    fTick = 1'b1;
    @(negedge clk);
    fTick = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      if (fDone) doneCount++;
      if (c == 20) rstN = 1'b0;
      if (c == 21) rstN = 1'b1;
      @(negedge clk);
    end
    check("abort_done_count", doneCount, 0);
    check("abort_busy", busy, 0);
    check("abort_score", score, 0);
    check("abort_enemy_kill", enemyKill, 0);
    check("abort_pb_kill", pBulletKill, 0);

    // Score build-up to saturation; stacked enemies are killed one per bullet
    clearField();
    for (int k = 0; k < 15; k++) setEnemy(k, 1'b1, mkPos(100, 100));
    for (int b = 0; b < 16; b++) begin
      pbAlive[b] = 1'b1;
      pbPos[b]   = mkPos(105, 105);
    end
    runScan(doneAt, busy1);
    check("stack_enemy_kill", enemyKill, 15'h7FFF);
    check("stack_pb_kill", pBulletKill, 16'h7FFF);
    check("stack_score", score, 15);
    for (int s = 1; s < 66; s++) runScan(doneAt, busy1);
    check("build_score_990", score, 990);

    for (int b = 8; b < 16; b++) pbAlive[b] = 1'b0;
    runScan(doneAt, busy1);
    check("build_score_998", score, 998);

    for (int b = 3; b < 16; b++) pbAlive[b] = 1'b0;
    runScan(doneAt, busy1);
    check("sat_enemy_kill", enemyKill, 15'h0007);
    check("sat_score", score, 999);

    pbAlive[2] = 1'b0;
    runScan(doneAt, busy1);
    check("sat_hold_latency", doneAt, 47);
    check("sat_hold_score", score, 999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 Parameter MAX_ENEMY, 15, number of enemy slots.
REQ-002 Parameter MAX_PLAYER_BULLET, 16, number of player bullet slots.
REQ-003 Parameter MAX_ENEMY_BULLET, 30, number of enemy bullet slots.
REQ-004 Parameters BULLET_WIDTH 6, BULLET_HEIGHT 20, OBJ_WIDTH 36, OBJ_HEIGHT 36, hitbox sizes in pixels.
REQ-005 i_Clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-006 i_Rst  in  1  reset, synchronous, active-low.
REQ-007 i_fTick  in  1  one-cycle pulse; starts one scan.
REQ-008 i_EnemyState  in  MAX_ENEMY  enemy alive mask.
REQ-009 i_EnemyPosFlat  in  19*MAX_ENEMY  enemy positions, slot k at bits [19k+18:19k].
REQ-010 i_PlayerState, i_PlayerPos  in  1, 19  player alive, player position.
REQ-011 o_PBulletIdx  out  4  player-bullet read index; i_PBulletAlive (1), i_PBulletPos (19) in, combinational same-cycle response.
REQ-012 o_EBulletIdx  out  5  enemy-bullet read index; i_EBulletAlive (1), i_EBulletPos (19) in, same-cycle response.
REQ-013 o_EnemyKill  out  MAX_ENEMY  enemies hit in last scan; o_PBulletKill  out  MAX_PLAYER_BULLET  player bullets consumed; o_EBulletKill  out  MAX_ENEMY_BULLET  enemy bullets that hit player.
REQ-014 o_fPlayerHit  out  1; o_fDone  out  1  one-cycle completion pulse; o_Busy  out  1; o_Score  out  10.

Function
REQ-015 Position format SHALL be {X[18:9] 10-bit, Y[8:0] 9-bit}, top-left corner; 19'h7FFFF (dead) SHALL never collide regardless of alive flag.
REQ-016 Overlap SHALL be bx < ox+OW and ox < bx+BW and by < oy+OH and oy < by+BH, evaluated at 11-bit unsigned width (no wrap).
REQ-017 FSM states IDLE, SCAN_PB, SCAN_EB, DONE; IDLE->SCAN_PB on i_fTick, SCAN_PB->SCAN_EB after index MAX_PLAYER_BULLET-1, SCAN_EB->DONE after index MAX_ENEMY_BULLET-1, DONE->IDLE unconditionally.
REQ-018 SCAN_PB SHALL examine one player bullet per cycle, indices 0..15 ascending, against all enemies in parallel.
REQ-019 An alive player bullet overlapping several alive enemies SHALL kill only the lowest-index one.
REQ-020 An enemy killed earlier in the same scan SHALL be excluded; a later bullet overlapping only it SHALL pass through (not consumed).
REQ-021 SCAN_EB SHALL examine one enemy bullet per cycle, indices 0..29; hits recorded only if i_PlayerState=1; all overlapping bullets flagged.
REQ-022 Working masks SHALL clear on scan start; o_EnemyKill, o_PBulletKill, o_EBulletKill, o_fPlayerHit SHALL load in DONE and hold until next DONE.
REQ-023 o_fDone SHALL pulse exactly in the DONE cycle; latency i_fTick to o_fDone = MAX_PLAYER_BULLET+MAX_ENEMY_BULLET+1 = 47 cycles.
REQ-024 o_Busy SHALL be 1 in SCAN_PB, SCAN_EB, DONE; i_fTick while busy SHALL be ignored (not queued).
REQ-025 o_Score SHALL add popcount of the scan's enemy kills in DONE, saturating at 999.
REQ-026 Index outputs SHALL read 0 in IDLE and DONE.

Reset
REQ-027 While i_Rst=0 at a rising edge: state IDLE, indices 0, all kill masks 0, o_fPlayerHit 0, o_fDone 0, o_Busy 0, o_Score 0.
REQ-028 Reset mid-scan SHALL abort without any output update or o_fDone pulse.

Structure
REQ-029 Position format, DEAD_POSITION, hitbox sizes, slot counts SHALL live in a shared game package used by the bullet generator and this block.
REQ-030 The overlap test SHALL be one sub-module, hitbox_overlap, instantiated MAX_ENEMY+1 times.

Verification
REQ-031 Bullet 3 at {300,100} alive, enemy 7 at {290,90} -> after 47 cycles o_EnemyKill=bit7, o_PBulletKill=bit3, o_Score=1.
REQ-032 Bullets 0 and 1 both overlap only enemy 2 -> only bullet 0 consumed, enemy 2 killed once, score +1.
REQ-033 Enemy bullets 5 and 20 overlap player at {302,372} -> o_EBulletKill bits 5,20, o_fPlayerHit=1; same with i_PlayerState=0 -> all 0.
REQ-034 Bullet at DEAD_POSITION with alive=1 over dead-corner enemy -> no kill; bullet edge exactly touching enemy (bx=ox+OW) -> no kill.
REQ-035 i_fTick repeated at cycle 10 of scan -> ignored, single o_fDone at cycle 47; reset at cycle 20 -> no o_fDone, outputs stay 0.
REQ-036 Score preset 998 via scans, scan with 3 kills -> o_Score=999.
